md_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS150 execute stage. Runs alongside the ALU and takes the same A/B operands from the ID/EX latch. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. The HI and LO registers feed the execute-stage result mux that selects between ALU `Out` and MFHI/MFLO. Shift-add multiply and restoring divide, one bit per cycle, with a busy/done handshake so the hazard unit can stall MFHI/MFLO.

---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_negate.sv | 12 +
 rtl/md_unit.sv | 126 ++++++++++++
 tb/tb_md_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - Shared encodings for the multiply/divide unit.
package md_unit_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_negate.sv
// rtl/md_negate.sv - Conditional two's-complement negate.
module md_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - Iterative shift-add multiply / restoring divide with HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       MDop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic               is_div, sign_q, sign_r;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, shifted, sub_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_fix, hi_fix, lo_fix;

  md_negate #(.W(WIDTH)) u_neg_a (
    .neg(op_is_signed(MDop) & A[WIDTH-1]), .value(A), .result(mag_a)
  );
  md_negate #(.W(WIDTH)) u_neg_b (
    .neg(op_is_signed(MDop) & B[WIDTH-1]), .value(B), .result(mag_b)
  );

  // acc holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  assign shifted  = acc[2*WIDTH-1:WIDTH-1];
  assign sub_diff = shifted - {1'b0, mcand};

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (sub_diff[WIDTH]) acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_step = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Low half of the negated 64-bit product doubles as the negated quotient
  md_negate #(.W(2*WIDTH)) u_neg_p (.neg(sign_q), .value(acc), .result(prod_fix));
  md_negate #(.W(WIDTH)) u_neg_r (
    .neg(sign_r), .value(acc[2*WIDTH-1:WIDTH]), .result(rem_fix)
  );

  assign lo_fix = prod_fix[WIDTH-1:0];
  assign hi_fix = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (count == LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      mcand  <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state == ST_FIX);
      if (state == ST_IDLE && start) begin
        is_div <= op_is_div(MDop);
        // Divide by zero keeps the quotient unsigned so LO reads all ones
        sign_q <= op_is_signed(MDop) & (A[WIDTH-1] ^ B[WIDTH-1])
                  & (~op_is_div(MDop) | (B != '0));
        sign_r <= op_is_signed(MDop) & A[WIDTH-1];
        count  <= '0;
        if (op_is_div(MDop)) begin
          mcand <= mag_b;
          acc   <= {{WIDTH{1'b0}}, mag_a};
        end else begin
          mcand <= mag_a;
          acc   <= {{WIDTH{1'b0}}, mag_b};
        end
      end else if (state == ST_IDLE) begin
        if (hi_we) HI <= wdata;
        if (lo_we) LO <= wdata;
      end else if (state == ST_RUN) begin
        acc   <= acc_step;
        count <= count + CW'(1);
      end else if (state == ST_FIX) begin
        HI <= hi_fix;
        LO <= lo_fix;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - Scoreboard bench for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  MDop = 2'd0;
  logic [31:0] A = '0, B = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MDop(MDop), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      2'd0: return 64'(sa * sbv);
      2'd1: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (op == 2'd3) return {a % b, a / b};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    MDop  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc, output logic busy_at_done);
    int n;
    n = 1;
    lat = -1;
    busy_cyc = int'(busy);
    busy_at_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        lat = n - 1;
        busy_at_done = busy;
        break;
      end
      busy_cyc += int'(busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", LO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic [1:0]  op [2] = '{2'd0, 2'd1};
    logic [31:0] a  [2] = '{32'd7, 32'hFFFFFFFF};
    logic [31:0] b  [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] eh [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] el [2] = '{32'hFFFFFFEB, 32'h00000001};
    int lat, bc;
    logic bd;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(op[i], a[i], b[i], eh[i], el[i]);
      wait_done(lat, bc, bd);
      e = sb.pop_front();
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mult%0d_latency: got %0d want 33", i, lat); end
      n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mult%0d_busy_cycles: got %0d want 33", i, bc); end
      n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL mult%0d_busy_in_done: got %b want 0", i, bd); end
      n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL mult%0d_hi: got %h want %h", i, HI, e.hi); end
      n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL mult%0d_lo: got %h want %h", i, LO, e.lo); end
    end
  endtask

  task automatic test_div();
    logic [1:0]  op [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
    logic [31:0] b  [4] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh [4] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
    logic [31:0] el [4] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
    int lat, bc;
    logic bd;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(op[i], a[i], b[i], eh[i], el[i]);
      wait_done(lat, bc, bd);
      e = sb.pop_front();
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div%0d_latency: got %0d want 33", i, lat); end
      n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, HI, e.hi); end
      n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL div%0d_lo: got %h want %h", i, LO, e.lo); end
    end
  endtask

  task automatic test_handshake();
    int lat, bc;
    logic bd;
    logic seen;
    exp_t e;
    issue(2'd1, 32'h00010000, 32'h00030000, 32'd3, 32'd0);
    repeat (3) @(negedge clk);
    MDop = 2'd3; A = 32'd9; B = 32'd3; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat, bc, bd);
    e = sb.pop_front();
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL hs_done_timeout: got none want done pulse"); end
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL hs_hi: got %h want %h", HI, e.hi); end
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL hs_lo: got %h want %h", LO, e.lo); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL hs_ignored_start: got extra op want none"); end
  endtask

  task automatic test_mt();
    int lat, bc;
    logic bd;
    exp_t e;
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    n_checks++; if (LO !== 32'hABCD) begin n_fail++; $display("FAIL mtlo: got %h want 0000abcd", LO); end
    n_checks++; if (HI !== 32'd3) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 00000003", HI); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++; if (HI !== 32'h5A5A) begin n_fail++; $display("FAIL mt_both_hi: got %h want 00005a5a", HI); end
    n_checks++; if (LO !== 32'h5A5A) begin n_fail++; $display("FAIL mt_both_lo: got %h want 00005a5a", LO); end
    lo_we = 1'b1; wdata = 32'h7777;
    issue(2'd0, 32'd2, 32'd3, 32'd0, 32'd6);
    lo_we = 1'b0;
    n_checks++; if (LO !== 32'h5A5A) begin n_fail++; $display("FAIL mtlo_vs_start: got %h want 00005a5a", LO); end
    wait_done(lat, bc, bd);
    e = sb.pop_front();
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL mt_start_lo: got %h want %h", LO, e.lo); end
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL mt_start_hi: got %h want %h", HI, e.hi); end
  endtask

  task automatic test_reset_midop();
    int lat, bc;
    logic bd;
    exp_t e;
    issue(2'd2, 32'd1000, 32'd7, 32'd6, 32'd142);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    n_checks++; if (HI !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", HI); end
    n_checks++; if (LO !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", LO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(2'd0, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_done(lat, bc, bd);
    e = sb.pop_front();
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL rst_after_lo: got %h want %h", LO, e.lo); end
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL rst_after_hi: got %h want %h", HI, e.hi); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic bd;
    exp_t e;
    issue(2'd3, 32'd1000, 32'd7, 32'd6, 32'd142);
    wait_done(lat, bc, bd);
    e = sb.pop_front();
    n_checks++; if (LO !== e.lo || HI !== e.hi) begin n_fail++; $display("FAIL b2b_first: got %h_%h want %h_%h", HI, LO, e.hi, e.lo); end
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);
    wait_done(lat, bc, bd);
    e = sb.pop_front();
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    n_checks++; if (LO !== e.lo || HI !== e.hi) begin n_fail++; $display("FAIL b2b_second: got %h_%h want %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic bd;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] m;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      m  = model(op, a, b);
      issue(op, a, b, m[63:32], m[31:0]);
      wait_done(lat, bc, bd);
      e = sb.pop_front();
      n_checks++;
      if (HI !== e.hi || LO !== e.lo) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, HI, LO, e.hi, e.lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_handshake();
    test_mt();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
